// File: rtl/change_dispenser.sv
// Greedy coin dispenser: ejects change as high/mid/unit coin pulses spaced PULSE_GAP cycles apart.
// Optional abort input enabled by defining CHANGE_ABORT_EN.
module change_dispenser #(
    parameter int unsigned PULSE_GAP = 4,
    parameter int unsigned COIN_HI   = 10,
    parameter int unsigned COIN_MID  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] change,
`ifdef CHANGE_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       coin_hi,
    output logic       coin_mid,
    output logic       coin_lo,
    output logic [4:0] dispensed,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        DISP,
        GAP,
        DONE
    } state_t;

    localparam logic [4:0] HI_V     = 5'(COIN_HI);
    localparam logic [4:0] MID_V    = 5'(COIN_MID);
    localparam logic [3:0] GAP_LOAD = 4'(PULSE_GAP - 2);

    state_t     state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic [4:0] disp_d;
    logic [3:0] gap_q, gap_d;
    logic       hi_d, mid_d, lo_d;
    logic       busy_d, done_d;
    logic       abort_req;

`ifdef CHANGE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        disp_d  = dispensed;
        gap_d   = gap_q;
        hi_d    = 1'b0;
        mid_d   = 1'b0;
        lo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DISP;
                    rem_d   = change;
                    disp_d  = '0;
                end
            end
            DISP: begin
                // Abort wins over the coin that would otherwise be ejected this cycle.
                if (abort_req || rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                    if (rem_q >= HI_V) begin
                        hi_d   = 1'b1;
                        rem_d  = rem_q - HI_V;
                        disp_d = dispensed + HI_V;
                    end else if (rem_q >= MID_V) begin
                        mid_d  = 1'b1;
                        rem_d  = rem_q - MID_V;
                        disp_d = dispensed + MID_V;
                    end else begin
                        lo_d   = 1'b1;
                        rem_d  = rem_q - 5'd1;
                        disp_d = dispensed + 5'd1;
                    end
                end
            end
            GAP: begin
                if (abort_req) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    state_d = DISP;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            gap_q     <= '0;
            dispensed <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            coin_hi   <= 1'b0;
            coin_mid  <= 1'b0;
            coin_lo   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            dispensed <= disp_d;
            busy      <= busy_d;
            done      <= done_d;
            coin_hi   <= hi_d;
            coin_mid  <= mid_d;
            coin_lo   <= lo_d;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser (PULSE_GAP=4, COIN_HI=10, COIN_MID=5).
// Abort scenario is exercised when CHANGE_ABORT_EN is defined.
module tb_change_dispenser;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] change;
    logic       abort;
    logic       busy;
    logic       coin_hi;
    logic       coin_mid;
    logic       coin_lo;
    logic [4:0] dispensed;
    logic       done;

    int vectors;
    int miscompares;
    int multi_hot;

    logic [2:0] coin_log [0:63];
    logic       done_log [0:63];
    logic       busy_log [0:63];
    logic [4:0] disp_log [0:63];

    change_dispenser #(
        .PULSE_GAP(4),
        .COIN_HI  (10),
        .COIN_MID (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .change   (change),
`ifdef CHANGE_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .coin_hi  (coin_hi),
        .coin_mid (coin_mid),
        .coin_lo  (coin_lo),
        .dispensed(dispensed),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive start for one edge (E0) and return 1 time unit after it.
    task automatic begin_txn(input logic [4:0] c);
        start  = 1'b1;
        change = c;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Record outputs after edges E1..En; optional start/reset/abort injections land on the given edge.
    task automatic capture(input int n, input int inj_k, input int inj_len, input logic [4:0] inj_chg,
                           input int rst_k, input int abort_k);
        multi_hot = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            coin_log[k] = {coin_hi, coin_mid, coin_lo};
            done_log[k] = done;
            busy_log[k] = busy;
            disp_log[k] = dispensed;
            if ($countones({coin_hi, coin_mid, coin_lo}) > 1) multi_hot++;
            start = (k + 1 >= inj_k) && (k + 1 < inj_k + inj_len);
            if (start) change = inj_chg;
            rst_n = !(k + 1 == rst_k);
            abort = (k + 1 == abort_k);
        end
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b1;
        change = 5'd7;
        repeat (3) @(posedge clk);
        #1;
        vectors += 4;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b expected 0", done); end
        if ({coin_hi, coin_mid, coin_lo} !== 3'b000) begin
            miscompares++; $display("FAIL reset_coins got %b expected 000", {coin_hi, coin_mid, coin_lo});
        end
        if (dispensed !== 5'd0) begin miscompares++; $display("FAIL reset_dispensed got %0d expected 0", dispensed); end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b expected 0", busy); end
    endtask

    task automatic test_change17;
        logic [2:0] exp_c;
        begin_txn(5'd17);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL c17_busy_e0 got %b expected 1", busy); end
        if (dispensed !== 5'd0) begin miscompares++; $display("FAIL c17_disp_e0 got %0d expected 0", dispensed); end
        capture(20, 0, 0, 5'd0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            case (k)
                1:       exp_c = 3'b100;
                5:       exp_c = 3'b010;
                9, 13:   exp_c = 3'b001;
                default: exp_c = 3'b000;
            endcase
            vectors += 2;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL c17_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
            if (done_log[k] !== (k == 17)) begin
                miscompares++; $display("FAIL c17_done cycle %0d got %b expected %b", k, done_log[k], k == 17);
            end
        end
        vectors += 4;
        if (disp_log[1] !== 5'd10) begin miscompares++; $display("FAIL c17_disp_e1 got %0d expected 10", disp_log[1]); end
        if (disp_log[17] !== 5'd17) begin miscompares++; $display("FAIL c17_disp_done got %0d expected 17", disp_log[17]); end
        if (busy_log[17] !== 1'b1) begin miscompares++; $display("FAIL c17_busy_done got %b expected 1", busy_log[17]); end
        if (busy_log[18] !== 1'b0) begin miscompares++; $display("FAIL c17_busy_after got %b expected 0", busy_log[18]); end
    endtask

    task automatic test_change31;
        logic [2:0] exp_c;
        int         dcount;
        begin_txn(5'd31);
        capture(20, 0, 0, 5'd0, 0, 0);
        dcount = 0;
        for (int k = 1; k <= 20; k++) begin
            case (k)
                1, 5, 9: exp_c = 3'b100;
                13:      exp_c = 3'b001;
                default: exp_c = 3'b000;
            endcase
            if (done_log[k]) dcount++;
            vectors++;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL c31_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
        end
        vectors += 4;
        if (done_log[17] !== 1'b1) begin miscompares++; $display("FAIL c31_done_e17 got %b expected 1", done_log[17]); end
        if (dcount !== 1) begin miscompares++; $display("FAIL c31_done_count got %0d expected 1", dcount); end
        if (disp_log[17] !== 5'd31) begin miscompares++; $display("FAIL c31_disp got %0d expected 31", disp_log[17]); end
        if (multi_hot !== 0) begin miscompares++; $display("FAIL c31_onehot got %0d expected 0", multi_hot); end
    endtask

    task automatic test_zero;
        begin_txn(5'd0);
        capture(4, 0, 0, 5'd0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            vectors += 2;
            if (coin_log[k] !== 3'b000) begin
                miscompares++; $display("FAIL zero_coins cycle %0d got %b expected 000", k, coin_log[k]);
            end
            if (done_log[k] !== (k == 1)) begin
                miscompares++; $display("FAIL zero_done cycle %0d got %b expected %b", k, done_log[k], k == 1);
            end
        end
        vectors += 3;
        if (busy_log[1] !== 1'b1) begin miscompares++; $display("FAIL zero_busy_e1 got %b expected 1", busy_log[1]); end
        if (busy_log[2] !== 1'b0) begin miscompares++; $display("FAIL zero_busy_e2 got %b expected 0", busy_log[2]); end
        if (disp_log[1] !== 5'd0) begin miscompares++; $display("FAIL zero_disp got %0d expected 0", disp_log[1]); end
    endtask

    task automatic test_busy_ignore;
        logic [2:0] exp_c;
        begin_txn(5'd9);
        capture(26, 3, 1, 5'd20, 0, 0);
        for (int k = 1; k <= 26; k++) begin
            case (k)
                1:               exp_c = 3'b010;
                5, 9, 13, 17:    exp_c = 3'b001;
                default:         exp_c = 3'b000;
            endcase
            vectors += 2;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL ignore_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
            if (done_log[k] !== (k == 21)) begin
                miscompares++; $display("FAIL ignore_done cycle %0d got %b expected %b", k, done_log[k], k == 21);
            end
        end
        vectors += 2;
        if (disp_log[21] !== 5'd9) begin miscompares++; $display("FAIL ignore_disp got %0d expected 9", disp_log[21]); end
        if (busy_log[22] !== 1'b0) begin miscompares++; $display("FAIL ignore_busy_after got %b expected 0", busy_log[22]); end
    endtask

    task automatic test_reset_mid;
        logic [2:0] exp_c;
        begin_txn(5'd25);
        capture(30, 0, 0, 5'd0, 6, 0);
        for (int k = 1; k <= 30; k++) begin
            exp_c = (k == 1 || k == 5) ? 3'b100 : 3'b000;
            vectors++;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL rstmid_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
            if (k >= 6) begin
                vectors++;
                if ({busy_log[k], done_log[k], disp_log[k]} !== 7'd0) begin
                    miscompares++;
                    $display("FAIL rstmid_outs cycle %0d got busy=%b done=%b disp=%0d expected all 0",
                             k, busy_log[k], done_log[k], disp_log[k]);
                end
            end
        end
        begin_txn(5'd3);
        capture(16, 0, 0, 5'd0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            exp_c = (k == 1 || k == 5 || k == 9) ? 3'b001 : 3'b000;
            vectors += 2;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL rstmid_next_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
            if (done_log[k] !== (k == 13)) begin
                miscompares++; $display("FAIL rstmid_next_done cycle %0d got %b expected %b", k, done_log[k], k == 13);
            end
        end
        vectors++;
        if (disp_log[13] !== 5'd3) begin miscompares++; $display("FAIL rstmid_next_disp got %0d expected 3", disp_log[13]); end
    endtask

    task automatic test_boundary;
        logic [4:0] amt  [0:2];
        logic [2:0] first[0:2];
        int         dk   [0:2];
        logic [2:0] exp_c;
        amt[0] = 5'd10; first[0] = 3'b100; dk[0] = 5;
        amt[1] = 5'd5;  first[1] = 3'b010; dk[1] = 5;
        amt[2] = 5'd4;  first[2] = 3'b001; dk[2] = 17;
        for (int t = 0; t < 3; t++) begin
            begin_txn(amt[t]);
            capture(dk[t] + 2, 0, 0, 5'd0, 0, 0);
            for (int k = 1; k <= dk[t] + 2; k++) begin
                exp_c = (k < dk[t] && (k % 4) == 1) ? first[t] : 3'b000;
                vectors += 2;
                if (coin_log[k] !== exp_c) begin
                    miscompares++;
                    $display("FAIL bound%0d_coins cycle %0d got %b expected %b", amt[t], k, coin_log[k], exp_c);
                end
                if (done_log[k] !== (k == dk[t])) begin
                    miscompares++;
                    $display("FAIL bound%0d_done cycle %0d got %b expected %b", amt[t], k, done_log[k], k == dk[t]);
                end
            end
            vectors++;
            if (disp_log[dk[t]] !== amt[t]) begin
                miscompares++; $display("FAIL bound%0d_disp got %0d expected %0d", amt[t], disp_log[dk[t]], amt[t]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_c;
        begin_txn(5'd1);
        capture(18, 6, 2, 5'd2, 0, 0);
        for (int k = 1; k <= 18; k++) begin
            exp_c = (k == 1 || k == 8 || k == 12) ? 3'b001 : 3'b000;
            vectors += 2;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL b2b_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
            if (done_log[k] !== (k == 5 || k == 16)) begin
                miscompares++; $display("FAIL b2b_done cycle %0d got %b expected %b", k, done_log[k], k == 5 || k == 16);
            end
        end
        vectors += 6;
        if (busy_log[6] !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_e6 got %b expected 0", busy_log[6]); end
        if (busy_log[7] !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_e7 got %b expected 1", busy_log[7]); end
        if (disp_log[6] !== 5'd1) begin miscompares++; $display("FAIL b2b_disp_e6 got %0d expected 1", disp_log[6]); end
        if (disp_log[7] !== 5'd0) begin miscompares++; $display("FAIL b2b_disp_e7 got %0d expected 0", disp_log[7]); end
        if (disp_log[16] !== 5'd2) begin miscompares++; $display("FAIL b2b_disp_done got %0d expected 2", disp_log[16]); end
        if (busy_log[17] !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end got %b expected 0", busy_log[17]); end
    endtask

`ifdef CHANGE_ABORT_EN
    task automatic test_abort;
        logic [2:0] exp_c;
        begin_txn(5'd27);
        capture(14, 0, 0, 5'd0, 0, 7);
        for (int k = 1; k <= 14; k++) begin
            exp_c = (k == 1 || k == 5) ? 3'b100 : 3'b000;
            vectors += 2;
            if (coin_log[k] !== exp_c) begin
                miscompares++; $display("FAIL abort_coins cycle %0d got %b expected %b", k, coin_log[k], exp_c);
            end
            if (done_log[k] !== (k == 7)) begin
                miscompares++; $display("FAIL abort_done cycle %0d got %b expected %b", k, done_log[k], k == 7);
            end
        end
        vectors += 2;
        if (disp_log[7] !== 5'd20) begin miscompares++; $display("FAIL abort_disp got %0d expected 20", disp_log[7]); end
        if (busy_log[8] !== 1'b0) begin miscompares++; $display("FAIL abort_busy_after got %b expected 0", busy_log[8]); end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        multi_hot   = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        change      = 5'd0;
        abort       = 1'b0;
        test_reset();
        test_change17();
        test_change31();
        test_zero();
        test_busy_ignore();
        test_reset_mid();
        test_boundary();
        test_back_to_back();
`ifdef CHANGE_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_GAP, default 4: clock cycles from one coin pulse's rising edge to the next, legal range 2..15.
REQ-002 Parameter COIN_HI, default 10: high denomination value.
REQ-003 Parameter COIN_MID, default 5: middle denomination value; the low denomination is fixed at 1.
REQ-004 clk  input  1: single clock; all logic on posedge.
REQ-005 rst_n  input  1: reset, synchronous, active-low.
REQ-006 start  input  1: request to dispense `change`; sampled in IDLE only.
REQ-007 change  input  5: change amount in units, 0..31, from the change computation stage.
REQ-008 busy  output  1: high from the cycle after start is accepted through the done cycle.
REQ-009 coin_hi, coin_mid, coin_lo  output  1 each: one-cycle pulse per coin ejected.
REQ-010 dispensed  output  5: running total of value ejected in the current transaction.
REQ-011 done  output  1: one-cycle pulse when the transaction completes.

Function
REQ-012 FSM states shall be IDLE, DISP, GAP and DONE, and every output shall be registered.
REQ-013 IDLE: start=1 at edge E0 -> latch remaining=change, clear dispensed, state DISP, busy=1 from E0.
REQ-014 DISP with remaining=0: at the edge -> state DONE, done=1 for exactly one cycle, no coin pulse.
REQ-015 DISP with remaining>0: select greedy denomination (COIN_HI if remaining>=COIN_HI, else COIN_MID if remaining>=COIN_MID, else 1), pulse the matching coin output for one cycle, subtract from remaining, add to dispensed, state GAP.
REQ-016 GAP shall hold for PULSE_GAP-1 cycles with all coin outputs 0, then return to DISP.
REQ-017 The first coin output shall be high during the cycle E1..E2, and consecutive coin pulses shall be exactly PULSE_GAP cycles apart.
REQ-018 DONE shall last one cycle; busy and done shall be low from the following edge, and state shall return to IDLE.
REQ-019 At most one coin output shall be high in any cycle.
REQ-020 At done, dispensed shall equal the latched change; no overflow is possible because the sum never exceeds change.
REQ-021 start while busy=1 shall be ignored, with no queuing; change may vary after acceptance without effect.
REQ-022 start in the DONE cycle shall be ignored; a new transaction may start in the first IDLE cycle.
REQ-023 Zero change: done shall be high during E1..E2 with no coin pulse.

Reset
REQ-024 rst_n=0 at any edge shall force IDLE, and busy, done, all coin outputs, dispensed and remaining shall be 0 from that edge.
REQ-025 Reset mid-transaction shall abandon remaining coins with no further pulses; start shall be ignored during reset.

Configuration
REQ-026 With CHANGE_ABORT_EN defined, an input abort (1 bit) shall exist.
REQ-027 With CHANGE_ABORT_EN, abort=1 in DISP or GAP shall go to DONE at the next edge, done shall pulse, dispensed shall hold the partial total, and no further coins shall be ejected.
REQ-028 With CHANGE_ABORT_EN, abort shall be ignored in IDLE and DONE, and abort takes priority over a coin selection in the same cycle.
REQ-029 Without CHANGE_ABORT_EN, the abort port shall be absent and every accepted transaction shall run to completion.

Verification
REQ-030 change=17, start one cycle, PULSE_GAP=4 -> coin_hi, coin_mid, coin_lo, coin_lo at E1, E5, E9, E13; done at E17; dispensed=17.
REQ-031 change=31 -> three coin_hi then one coin_lo; done once; dispensed=31; never two coin outputs high in one cycle.
REQ-032 change=0 -> no coin pulses; done high E1..E2; busy low from E2.
REQ-033 change=9, second start with change=20 at E3 -> ignored; coin_mid then 4 coin_lo; dispensed=9.
REQ-034 change=25, rst_n=0 at E6 -> all outputs 0 from E6; no later pulses; next start with change=3 works normally.
REQ-035 With CHANGE_ABORT_EN, change=27, abort at E6 -> coins at E1 and E5 only; done at E7; dispensed=20.
